// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mult_arbiter
//  Description : Round-robin arbiter sharing one shift-add multiplier core
//                between N_REQ requesters. Latches the winner's operands,
//                drives the core through a level start/ready handshake,
//                returns the product with a one-cycle done pulse, and aborts
//                through a watchdog when the core never answers.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   a_in,
  input  logic [N_REQ*WIDTH-1:0]   b_in,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic [2*WIDTH-1:0]       product,
  output logic                     busy,
  output logic                     timeout_err,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic                     mul_ready,
  input  logic [2*WIDTH-1:0]       mul_product
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [PTR_W-1:0]     r_rr_ptr;
  logic [PTR_W-1:0]     w_rr_ptr_nxt;
  logic [WD_W-1:0]      r_wd;
  logic [WD_W-1:0]      w_wd_nxt;
  logic [N_REQ-1:0]     r_gnt;
  logic [N_REQ-1:0]     w_gnt_nxt;
  logic [N_REQ-1:0]     r_done;
  logic [N_REQ-1:0]     w_done_nxt;
  logic [2*WIDTH-1:0]   r_product;
  logic [2*WIDTH-1:0]   w_product_nxt;
  logic                 r_busy;
  logic                 w_busy_nxt;
  logic                 r_timeout_err;
  logic                 w_timeout_err_nxt;
  logic                 r_mul_start;
  logic                 w_mul_start_nxt;
  logic [WIDTH-1:0]     r_mul_a;
  logic [WIDTH-1:0]     w_mul_a_nxt;
  logic [WIDTH-1:0]     r_mul_b;
  logic [WIDTH-1:0]     w_mul_b_nxt;

  // Round-robin search results
  logic                 w_found;
  logic [PTR_W-1:0]     w_winner;
  logic [PTR_W:0]       w_sum;
  logic [PTR_W-1:0]     w_idx;

  // Operand slices unpacked per requester so the winner can select them
  logic [WIDTH-1:0]     w_a_arr [N_REQ];
  logic [WIDTH-1:0]     w_b_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_a_arr[gi] = a_in[gi*WIDTH +: WIDTH];
      assign w_b_arr[gi] = b_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Pick the first requesting index at or above rr_ptr, wrapping modulo N_REQ
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(N_REQ)) begin
        w_sum = w_sum - (PTR_W+1)'(N_REQ);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output logic; every output register is loaded from here
  always_comb begin
    w_state_nxt       = r_state;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_wd_nxt          = r_wd;
    w_gnt_nxt         = r_gnt;
    w_done_nxt        = '0;
    w_product_nxt     = r_product;
    w_timeout_err_nxt = r_timeout_err;
    w_mul_start_nxt   = r_mul_start;
    w_mul_a_nxt       = r_mul_a;
    w_mul_b_nxt       = r_mul_b;

    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt  = S_GRANT;
          w_gnt_nxt    = N_REQ'(1) << w_winner;
          w_mul_a_nxt  = w_a_arr[w_winner];
          w_mul_b_nxt  = w_b_arr[w_winner];
          w_rr_ptr_nxt = (w_winner == PTR_W'(N_REQ-1)) ? '0 : w_winner + 1'b1;
          w_wd_nxt     = '0;
        end
      end

      S_GRANT: begin
        w_state_nxt     = S_RUN;
        w_mul_start_nxt = 1'b1;
        w_wd_nxt        = '0;
      end

      S_RUN: begin
        if (mul_ready) begin
          w_state_nxt     = S_DONE;
          w_product_nxt   = mul_product;
          w_mul_start_nxt = 1'b0;
          w_done_nxt      = r_gnt;
        end else if (r_wd == WD_W'(TIMEOUT-1)) begin
          // Core has not answered within the budget: abort with a zero result
          w_state_nxt       = S_DONE;
          w_product_nxt     = '0;
          w_timeout_err_nxt = 1'b1;
          w_mul_start_nxt   = 1'b0;
          w_done_nxt        = r_gnt;
        end else begin
          w_wd_nxt = r_wd + 1'b1;
        end
      end

      S_DONE: begin
        w_state_nxt = S_DRAIN;
        w_gnt_nxt   = '0;
      end

      S_DRAIN: begin
        // Hold off the next grant until the core has released ready
        if (!mul_ready) begin
          w_state_nxt = S_IDLE;
          w_wd_nxt    = '0;
        end
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_gnt_nxt       = '0;
        w_mul_start_nxt = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_rr_ptr      <= '0;
      r_wd          <= '0;
      r_gnt         <= '0;
      r_done        <= '0;
      r_product     <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_mul_start   <= 1'b0;
      r_mul_a       <= '0;
      r_mul_b       <= '0;
    end else begin
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_wd          <= w_wd_nxt;
      r_gnt         <= w_gnt_nxt;
      r_done        <= w_done_nxt;
      r_product     <= w_product_nxt;
      r_busy        <= w_busy_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_mul_start   <= w_mul_start_nxt;
      r_mul_a       <= w_mul_a_nxt;
      r_mul_b       <= w_mul_b_nxt;
    end
  end

  assign gnt         = r_gnt;
  assign done        = r_done;
  assign product     = r_product;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign mul_start   = r_mul_start;
  assign mul_a       = r_mul_a;
  assign mul_b       = r_mul_b;

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_arbiter
//  Description : Scoreboard bench for mult_arbiter with a behavioural
//                multiplier core model (programmable latency, hang, ready hold).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;

  localparam int N_REQ   = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 32;

  logic                   clk = 1'b0;
  logic                   n_reset = 1'b0;
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ*WIDTH-1:0] a_in;
  logic [N_REQ*WIDTH-1:0] b_in;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic [2*WIDTH-1:0]     product;
  logic                   busy;
  logic                   timeout_err;
  logic                   mul_start;
  logic [WIDTH-1:0]       mul_a;
  logic [WIDTH-1:0]       mul_b;
  logic                   mul_ready = 1'b0;
  logic [2*WIDTH-1:0]     mul_product = '0;

  logic [WIDTH-1:0]       a_op [N_REQ];
  logic [WIDTH-1:0]       b_op [N_REQ];

  assign a_in = {a_op[3], a_op[2], a_op[1], a_op[0]};
  assign b_in = {b_op[3], b_op[2], b_op[1], b_op[0]};

  mult_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .n_reset(n_reset), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done(done), .product(product), .busy(busy),
    .timeout_err(timeout_err), .mul_start(mul_start), .mul_a(mul_a),
    .mul_b(mul_b), .mul_ready(mul_ready), .mul_product(mul_product)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] prod;
    logic        terr;
  } exp_t;

  exp_t       sb [$];
  logic [3:0] gnt_log [$];
  logic [3:0] gnt_prev = '0;

  int n_checks = 0;
  int n_fails  = 0;

  int core_delay = 1;
  bit core_hang  = 1'b0;
  int core_hold  = 0;
  int run_cnt    = 0;
  int hold_cnt   = 0;

  // Core model: ready after core_delay cycles of start, optionally held longer
  always @(negedge clk) begin
    if (!n_reset) begin
      mul_ready = 1'b0;
      run_cnt   = 0;
      hold_cnt  = 0;
    end else if (mul_start) begin
      run_cnt = run_cnt + 1;
      if (!core_hang && run_cnt >= core_delay) begin
        mul_ready   = 1'b1;
        mul_product = 16'(mul_a) * 16'(mul_b);
        hold_cnt    = core_hold;
      end
    end else begin
      run_cnt = 0;
      if (mul_ready) begin
        if (hold_cnt > 0) hold_cnt = hold_cnt - 1;
        else mul_ready = 1'b0;
      end
    end
  end

  // Record each new grant
  always @(negedge clk) begin
    if (gnt != 4'b0 && gnt_prev == 4'b0) gnt_log.push_back(gnt);
    gnt_prev = gnt;
  end

  // Monitor: every done pulse is matched against the oldest expected result
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] oh;
    if (n_reset && done != 4'b0) begin
      n_checks = n_checks + 1;
      if (sb.size() == 0) begin
        n_fails = n_fails + 1;
        $display("FAIL unexpected_done: done=%b product=%0d, nothing expected", done, product);
      end else begin
        e  = sb.pop_front();
        oh = 4'b0001 << e.idx;
        if (done !== oh || gnt !== oh || product !== e.prod || timeout_err !== e.terr) begin
          n_fails = n_fails + 1;
          $display("FAIL done_result: done=%b gnt=%b product=%0d terr=%b, expected done=gnt=%b product=%0d terr=%b",
                   done, gnt, product, timeout_err, oh, e.prod, e.terr);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fails = n_fails + 1;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push(input logic [1:0] idx, input logic [15:0] prod, input logic terr);
    exp_t e;
    e.idx  = idx;
    e.prod = prod;
    e.terr = terr;
    sb.push_back(e);
  endtask

  task automatic set_ops(input logic [1:0] i, input logic [7:0] a, input logic [7:0] b);
    a_op[i] = a;
    b_op[i] = b;
  endtask

  // Wait for a done pulse; counts cycles and cycles with mul_start high
  task automatic wait_done(input int limit, output int cyc, output int st);
    cyc = 0;
    st  = 0;
    while (1) begin
      @(negedge clk);
      cyc = cyc + 1;
      if (mul_start) st = st + 1;
      if (done != 4'b0) break;
      if (cyc >= limit) begin
        n_checks = n_checks + 1;
        n_fails  = n_fails + 1;
        $display("FAIL done_wait: no done after %0d cycles", cyc);
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n = n + 1;
    end
    check("return_to_idle", {31'b0, busy}, 0);
  endtask

  int cyc, st, gap;
  logic [3:0] fair_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    for (int i = 0; i < N_REQ; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
    end
    n_reset = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    check("rst_busy_terr_start", {busy, timeout_err, mul_start}, 0);
    check("rst_mul_ab", {mul_a, mul_b}, 0);
    n_reset = 1'b1;
    @(negedge clk);

    // Single operation: 13 * 11 with a 9-cycle core
    set_ops(0, 8'd13, 8'd11);
    core_delay = 9;
    push(0, 16'd143, 1'b0);
    req = 4'b0001;
    @(negedge clk);
    check("single_gnt", gnt, 4'b0001);
    check("single_mul_a", mul_a, 13);
    check("single_mul_b", mul_b, 11);
    check("single_busy", {31'b0, busy}, 1);
    wait_done(200, cyc, st);
    req = 4'b0000;
    check("single_latency", cyc + 1, 9 + 2);
    wait_idle();

    // Restart pointer, then all four requesting continuously
    n_reset = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    core_delay = 3;
    set_ops(0, 8'd25, 8'd4);
    set_ops(1, 8'd200, 8'd3);
    set_ops(2, 8'd255, 8'd255);
    set_ops(3, 8'd16, 8'd16);
    push(0, 16'd100, 1'b0);
    push(1, 16'd600, 1'b0);
    push(2, 16'd65025, 1'b0);
    push(3, 16'd256, 1'b0);
    push(0, 16'd100, 1'b0);
    gnt_log.delete();
    req = 4'b1111;
    for (int n = 0; n < 5; n++) wait_done(200, cyc, st);
    req = 4'b0000;
    wait_idle();
    check("fair_grant_count", gnt_log.size(), 5);
    for (int n = 0; n < 5; n++) begin
      check("fair_grant_order", (n < gnt_log.size()) ? gnt_log[n] : 4'b0, fair_exp[n]);
    end

    // Serve index 2, then req=1010 must go to 3 and wrap to 1
    set_ops(2, 8'd12, 8'd12);
    push(2, 16'd144, 1'b0);
    req = 4'b0100;
    wait_done(200, cyc, st);
    req = 4'b0000;
    wait_idle();
    set_ops(1, 8'd9, 8'd7);
    set_ops(3, 8'd100, 8'd100);
    push(3, 16'd10000, 1'b0);
    push(1, 16'd63, 1'b0);
    gnt_log.delete();
    req = 4'b1010;
    wait_done(200, cyc, st);
    wait_done(200, cyc, st);
    req = 4'b0000;
    wait_idle();
    check("wrap_first_grant", (gnt_log.size() > 0) ? gnt_log[0] : 4'b0, 4'b1000);
    check("wrap_second_grant", (gnt_log.size() > 1) ? gnt_log[1] : 4'b0, 4'b0010);

    // Hung core: watchdog abort after TIMEOUT RUN cycles, then a normal op
    check("terr_before", {31'b0, timeout_err}, 0);
    core_hang = 1'b1;
    set_ops(0, 8'd5, 8'd6);
    push(0, 16'd0, 1'b1);
    req = 4'b0001;
    wait_done(200, cyc, st);
    req = 4'b0000;
    check("timeout_run_cycles", st, TIMEOUT);
    core_hang = 1'b0;
    wait_idle();
    set_ops(1, 8'd7, 8'd9);
    push(1, 16'd63, 1'b1);
    req = 4'b0010;
    wait_done(200, cyc, st);
    req = 4'b0000;
    wait_idle();
    check("terr_sticky", {31'b0, timeout_err}, 1);

    // Reset in the middle of RUN
    set_ops(0, 8'd50, 8'd40);
    core_delay = 20;
    req = 4'b1111;
    for (int n = 0; n < 20 && !mul_start; n++) @(negedge clk);
    check("midrst_run_reached", {31'b0, mul_start}, 1);
    repeat (2) @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    check("midrst_gnt_done", {gnt, done}, 0);
    check("midrst_flags", {busy, timeout_err, mul_start}, 0);
    check("midrst_product", product, 0);
    check("midrst_mul_ab", {mul_a, mul_b}, 0);
    gnt_log.delete();
    push(0, 16'd2000, 1'b0);
    @(negedge clk);
    core_delay = 4;
    n_reset = 1'b1;
    wait_done(200, cyc, st);
    req = 4'b0000;
    wait_idle();
    check("midrst_first_grant", (gnt_log.size() > 0) ? gnt_log[0] : 4'b0, 4'b0001);

    // Core holds ready after DONE: no new grant until it falls
    core_delay = 2;
    core_hold  = 3;
    set_ops(1, 8'd17, 8'd3);
    set_ops(2, 8'd128, 8'd2);
    push(1, 16'd51, 1'b0);
    push(2, 16'd256, 1'b0);
    req = 4'b1111;
    wait_done(200, cyc, st);
    gap = 0;
    do begin
      @(negedge clk);
      gap = gap + 1;
    end while (gnt == 4'b0 && gap < 20);
    check("drain_regrant_gap", gap, 5);
    check("drain_next_gnt", gnt, 4'b0100);
    wait_done(200, cyc, st);
    req = 4'b0000;
    core_hold = 0;
    wait_idle();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
